// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//   Configurable UART transmitter. Serialises a DATA_W-bit word onto TX as
//   start bit, DATA_W data bits (LSB first), optional parity bit and one or
//   two stop bits. Divisor, parity mode and stop-bit count are captured when
//   a frame is accepted, so the register block may change them at any time.
//
//   Optional build macro: UART_TX_HOLD_EN
//     Adds a one-entry holding register (data + config). A request made while
//     a frame is in flight is parked there and launched directly after the
//     last stop bit, without an idle cycle. Without the macro, requests made
//     while busy are dropped.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   trmt      transmit request (pulse or level), taken when ready=1
//   tx_data   word to send, LSB first
//   divisor   bit period = divisor+1 clocks (0 is treated as 1)
//   par_mode  00 none, 01 even, 10 odd, 11 mark
//   two_stop  1 = two stop bits
//   TX        serial line, idle high
//   busy      frame in progress
//   ready     a request can be accepted this cycle
//   tx_done   set when the last frame completes, cleared on next accept
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
   parameter int unsigned       DATA_W  = 8,
   parameter int unsigned       DIV_W   = 13,
   parameter logic [DIV_W-1:0]  RST_DIV = 13'h01B2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trmt,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [DIV_W-1:0]  divisor,
   input  logic [1:0]        par_mode,
   input  logic              two_stop,
   output logic              TX,
   output logic              busy,
   output logic              ready,
   output logic              tx_done
);

   // state  | meaning
   // IDLE   | line high, waiting for a request
   // START  | start bit (low) for one bit period
   // DATA   | data bits, LSB first, bit_q counts 0..DATA_W-1
   // PARITY | parity bit, only when par_mode != 00
   // STOP   | stop bit(s), high; stop2_q marks the second of two
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam int unsigned      BCW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BCW-1:0]   LAST_BIT = BCW'(DATA_W - 1);

   state_t              state_q,   state_d;
   logic [DIV_W-1:0]    baud_q,    baud_d;
   logic [DIV_W-1:0]    div_q,     div_d;
   logic [BCW-1:0]      bit_q,     bit_d;
   logic [DATA_W-1:0]   shift_q,   shift_d;
   logic                par_en_q,  par_en_d;
   logic                par_bit_q, par_bit_d;
   logic                two_q,     two_d;
   logic                stop2_q,   stop2_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;

   // Frame loader: one set of source signals feeds every launch path
   logic                ld_en;
   logic [DATA_W-1:0]   ld_data;
   logic [DIV_W-1:0]    ld_div;
   logic [1:0]          ld_par;
   logic                ld_two;
   logic [DIV_W-1:0]    ld_div_c;
   logic                ld_par_bit;

   logic                bnd;
   logic                frame_end;
   logic                tx_c;

`ifdef UART_TX_HOLD_EN
   logic                hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0]   hold_data_q,  hold_data_d;
   logic [DIV_W-1:0]    hold_div_q,   hold_div_d;
   logic [1:0]          hold_par_q,   hold_par_d;
   logic                hold_two_q,   hold_two_d;

   assign ready = ~hold_valid_q;
`else
   assign ready = ~busy_q;
`endif

   assign busy    = busy_q;
   assign tx_done = done_q;
   assign TX      = tx_c;

   // A divisor of 0 would give a one-clock bit; the minimum period is two.
   assign ld_div_c = (ld_div == '0) ? DIV_W'(1) : ld_div;

   always_comb begin
      ld_par_bit = 1'b0;
      case (ld_par)
         2'b01:   ld_par_bit = ^ld_data;
         2'b10:   ld_par_bit = ~(^ld_data);
         2'b11:   ld_par_bit = 1'b1;
         default: ld_par_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      div_d     = div_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      two_d     = two_q;
      stop2_d   = stop2_q;
      busy_d    = busy_q;
      done_d    = done_q;
      ld_en     = 1'b0;
      ld_data   = tx_data;
      ld_div    = divisor;
      ld_par    = par_mode;
      ld_two    = two_stop;
      frame_end = 1'b0;
`ifdef UART_TX_HOLD_EN
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_div_d   = hold_div_q;
      hold_par_d   = hold_par_q;
      hold_two_d   = hold_two_q;
`endif

      bnd = (baud_q == '0);
      if (state_q != S_IDLE) begin
         baud_d = bnd ? div_q : (baud_q - DIV_W'(1));
      end

      case (state_q)
         S_IDLE: begin
            if (trmt && ready) begin
               ld_en = 1'b1;
            end
         end
         S_START: begin
            if (bnd) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bnd) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
                  stop2_d = 1'b0;
               end else begin
                  bit_d = bit_q + BCW'(1);
               end
            end
         end
         S_PARITY: begin
            if (bnd) begin
               state_d = S_STOP;
               stop2_d = 1'b0;
            end
         end
         S_STOP: begin
            if (bnd) begin
               if (two_q && !stop2_q) begin
                  stop2_d = 1'b1;
               end else begin
                  frame_end = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (frame_end) begin
`ifdef UART_TX_HOLD_EN
         // Chain straight into the parked frame; a request arriving on this
         // very edge (hold empty, so ready=1) is launched the same way.
         if (hold_valid_q) begin
            ld_en        = 1'b1;
            ld_data      = hold_data_q;
            ld_div       = hold_div_q;
            ld_par       = hold_par_q;
            ld_two       = hold_two_q;
            hold_valid_d = 1'b0;
         end else if (trmt) begin
            ld_en = 1'b1;
         end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
`else
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
`endif
      end

`ifdef UART_TX_HOLD_EN
      if (!frame_end && busy_q && trmt && !hold_valid_q) begin
         hold_valid_d = 1'b1;
         hold_data_d  = tx_data;
         hold_div_d   = divisor;
         hold_par_d   = par_mode;
         hold_two_d   = two_stop;
      end
`endif

      if (ld_en) begin
         state_d   = S_START;
         shift_d   = ld_data;
         div_d     = ld_div_c;
         baud_d    = ld_div_c;
         par_en_d  = (ld_par != 2'b00);
         par_bit_d = ld_par_bit;
         two_d     = ld_two;
         stop2_d   = 1'b0;
         bit_d     = '0;
         busy_d    = 1'b1;
         done_d    = 1'b0;
      end
   end

   always_comb begin
      tx_c = 1'b1;
      case (state_q)
         S_START:  tx_c = 1'b0;
         S_DATA:   tx_c = shift_q[0];
         S_PARITY: tx_c = par_bit_q;
         default:  tx_c = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         baud_q    <= RST_DIV;
         div_q     <= RST_DIV;
         bit_q     <= '0;
         shift_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         two_q     <= 1'b0;
         stop2_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         two_q     <= two_d;
         stop2_q   <= stop2_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef UART_TX_HOLD_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_div_q   <= '0;
         hold_par_q   <= 2'b00;
         hold_two_q   <= 1'b0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_div_q   <= hold_div_d;
         hold_par_q   <= hold_par_d;
         hold_two_q   <= hold_two_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Stimulus pushes the expected serial frame (bit list, bit period, accept
//   cycle) into a scoreboard queue; an independent monitor watches TX for a
//   start bit, pops the next expected frame and checks every bit, the frame
//   timing and the busy/tx_done state at the end of the frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

   localparam int DATA_W = 8;
   localparam int DIV_W  = 13;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              trmt = 1'b0;
   logic [DATA_W-1:0] tx_data = '0;
   logic [DIV_W-1:0]  divisor = '0;
   logic [1:0]        par_mode = 2'b00;
   logic              two_stop = 1'b0;
   logic              TX, busy, ready, tx_done;

   uart_tx_cfg #(.DATA_W(DATA_W), .DIV_W(DIV_W), .RST_DIV(13'h01B2)) dut (
      .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
      .divisor(divisor), .par_mode(par_mode), .two_stop(two_stop),
      .TX(TX), .busy(busy), .ready(ready), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          per;
      int          acc;
      int          id;
   } frame_t;

   frame_t sb[$];
   int passed = 0;
   int total = 0;
   int model_done = 0;
   int frame_id = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      else passed++;
   endtask

   // Reference frame: built directly from the line format.
   function automatic frame_t mk(input logic [DATA_W-1:0] d, input int dv,
                                 input logic [1:0] pm, input logic ts, input int acc);
      frame_t f;
      int n, ones;
      f.bits = '0;
      f.per = ((dv == 0) ? 1 : dv) + 1;
      f.acc = acc;
      f.id = frame_id;
      ones = $countones(d);
      f.bits[0] = 1'b0;
      n = 1;
      for (int i = 0; i < DATA_W; i++) begin
         f.bits[n] = d[i];
         n++;
      end
      if (pm != 2'b00) begin
         if (pm == 2'b11)      f.bits[n] = 1'b1;
         else if (pm == 2'b01) f.bits[n] = (ones % 2) == 1;
         else                  f.bits[n] = (ones % 2) == 0;
         n++;
      end
      f.bits[n] = 1'b1;
      n++;
      if (ts) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.nbits = n;
      return f;
   endfunction

   task automatic wait_idle();
      @(negedge clk);
      while (cyc < model_done) @(negedge clk);
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input int dv, input logic [1:0] pm,
                       input logic ts, output int acc);
      frame_t f;
      wait_idle();
      chk("ready_before_send", int'(ready), 1);
      tx_data = d; divisor = DIV_W'(dv); par_mode = pm; two_stop = ts; trmt = 1'b1;
      acc = cyc + 1;
      frame_id++;
      f = mk(d, dv, pm, ts, acc);
      sb.push_back(f);
      model_done = acc + f.nbits * f.per;
      @(negedge clk);
      trmt = 1'b0;
   endtask

   // Monitor
   initial begin : monitor
      frame_t e;
      bit skip;
      bit aborted;
      int nmatch;
      skip = 0;
      forever begin
         if (!skip) @(negedge clk);
         skip = 0;
         if (rst_n !== 1'b1 || TX !== 1'b0) continue;
         if (sb.size() == 0) begin
            chk("unexpected_start_bit", sb.size(), 1);
            for (int i = 0; i < 200 && TX === 1'b0; i++) @(negedge clk);
            continue;
         end
         e = sb.pop_front();
         chk($sformatf("f%0d_start_cycle", e.id), cyc, e.acc);
         chk($sformatf("f%0d_busy_in_frame", e.id), int'(busy), 1);
         chk($sformatf("f%0d_done_low_in_frame", e.id), int'(tx_done), 0);
         aborted = 0;
         for (int b = 0; b < e.nbits && !aborted; b++) begin
            nmatch = 0;
            for (int c = 0; c < e.per; c++) begin
               if (b != 0 || c != 0) @(negedge clk);
               if (rst_n !== 1'b1) begin
                  aborted = 1;
                  break;
               end
               if (TX === e.bits[b]) nmatch++;
            end
            if (!aborted) chk($sformatf("f%0d_bit%0d_clocks", e.id, b), nmatch, e.per);
         end
         if (!aborted) begin
            @(negedge clk);
            skip = 1;
            if (rst_n === 1'b1) begin
               if (sb.size() != 0 && sb[0].acc == cyc) begin
                  chk($sformatf("f%0d_busy_chained", e.id), int'(busy), 1);
                  chk($sformatf("f%0d_no_done_chained", e.id), int'(tx_done), 0);
               end else begin
                  chk($sformatf("f%0d_tx_done", e.id), int'(tx_done), 1);
                  chk($sformatf("f%0d_busy_end", e.id), int'(busy), 0);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int acc;
      frame_t f;
      logic [DATA_W-1:0] rd;
      #1;
      chk("reset_TX", int'(TX), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ready", int'(ready), 1);
      chk("reset_tx_done", int'(tx_done), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed frames: basic 8N1, each parity mode, clamped divisor + 2 stop
      send(8'hA5, 3, 2'b00, 1'b0, acc);
      send(8'hA5, 3, 2'b01, 1'b0, acc);
      send(8'hA5, 3, 2'b10, 1'b0, acc);
      send(8'hA5, 3, 2'b11, 1'b0, acc);
      send(8'h00, 0, 2'b00, 1'b1, acc);

      // Config and data change mid-frame must not disturb the frame
      send(8'hA5, 3, 2'b00, 1'b0, acc);
      while (cyc < acc + 5) @(negedge clk);
      divisor = 13'd7; tx_data = 8'h3C; par_mode = 2'b11; two_stop = 1'b1;
      send(8'h3C, 7, 2'b00, 1'b0, acc);

      // Request during a frame at cycle 10
      send(8'hA5, 3, 2'b00, 1'b0, acc);
      while (cyc < acc + 10) @(negedge clk);
      chk("busy_mid_frame", int'(busy), 1);
`ifdef UART_TX_HOLD_EN
      chk("ready_hold_empty", int'(ready), 1);
`else
      chk("ready_low_busy", int'(ready), 0);
`endif
      tx_data = 8'h5A; divisor = 13'd2; par_mode = 2'b10; two_stop = 1'b1; trmt = 1'b1;
`ifdef UART_TX_HOLD_EN
      frame_id++;
      f = mk(8'h5A, 2, 2'b10, 1'b1, model_done);
      sb.push_back(f);
      model_done = f.acc + f.nbits * f.per;
`endif
      @(negedge clk);
      trmt = 1'b0;
`ifdef UART_TX_HOLD_EN
      chk("ready_hold_full", int'(ready), 0);
`endif

      // Reset in the middle of a frame
      send(8'hA5, 3, 2'b00, 1'b0, acc);
      while (cyc < acc + 17) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_TX", int'(TX), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_tx_done", int'(tx_done), 0);
      chk("midrst_ready", int'(ready), 1);
      model_done = 0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      send(8'hA5, 3, 2'b00, 1'b0, acc);

      // Randomized frames
      for (int i = 0; i < 10; i++) begin
         rd = DATA_W'($urandom);
         send(rd, int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), acc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      chk("final_tx_done", int'(tx_done), 1);
      chk("final_busy", int'(busy), 0);
      chk("final_TX_idle", int'(TX), 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
